// File: rtl/matrix_alu_seq.sv
// Sequential signed matrix ALU: saturating elementwise ops complete in one EXEC cycle,
// and matrix multiply produces one dot-product element per cycle.
module matrix_alu_seq #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                opcode,
  input  logic [2:0]                size,
  input  logic [ELEM_W-1:0]         scalar,
  input  logic [ELEM_W*DIM*DIM-1:0] matrizA,
  input  logic [ELEM_W*DIM*DIM-1:0] matrizB,
  output logic [ELEM_W*DIM*DIM-1:0] result,
  output logic                      done,
  output logic                      busy,
  output logic                      overflow,
  output logic                      invalid_op
);

  localparam int MAT_W = ELEM_W * DIM * DIM;
  localparam int ACC_W = 2 * ELEM_W + 3;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (ELEM_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2 ** (ELEM_W - 1)));
  localparam logic [2:0] DIM_N = 3'(DIM);

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_TRN = 4'b0110;
  localparam logic [3:0] OP_NEG = 4'b0111;
  localparam logic [3:0] OP_SCL = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t                   r_state;
  logic [MAT_W-1:0]         r_a;
  logic [MAT_W-1:0]         r_b;
  logic [ELEM_W-1:0]        r_scalar;
  logic [3:0]               r_op;
  logic [2:0]               r_n;
  logic [2:0]               r_row;
  logic [2:0]               r_col;
  logic [MAT_W-1:0]         r_result;
  logic                     r_done;
  logic                     r_busy;
  logic                     r_overflow;
  logic                     r_invalid;

  logic                     w_legal;
  logic [MAT_W-1:0]         w_execRes;
  logic                     w_execOvf;
  logic signed [ACC_W-1:0]  w_dot;

  function automatic logic signed [ACC_W-1:0] ext(input logic [ELEM_W-1:0] e);
    return ACC_W'(signed'(e));
  endfunction

  function automatic logic [ELEM_W-1:0] satVal(input logic signed [ACC_W-1:0] v);
    if (v > MAXV) return MAXV[ELEM_W-1:0];
    else if (v < MINV) return MINV[ELEM_W-1:0];
    else return v[ELEM_W-1:0];
  endfunction

  function automatic logic isSat(input logic signed [ACC_W-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Whole-matrix elementwise result; anything outside the active n x n window stays zero.
  always_comb begin
    logic signed [ACC_W-1:0] vA, vB, vT, vS, vOut;
    w_legal   = (r_n != 3'd0) && (r_n <= DIM_N) && (r_op >= OP_ADD) && (r_op <= OP_SCL);
    w_execRes = '0;
    w_execOvf = 1'b0;
    vS        = ext(r_scalar);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        vA = ext(r_a[(r*DIM+c)*ELEM_W +: ELEM_W]);
        vB = ext(r_b[(r*DIM+c)*ELEM_W +: ELEM_W]);
        vT = ext(r_a[(c*DIM+r)*ELEM_W +: ELEM_W]);
        case (r_op)
          OP_ADD:  vOut = vA + vB;
          OP_SUB:  vOut = vA - vB;
          OP_TRN:  vOut = vT;
          OP_NEG:  vOut = -vA;
          OP_SCL:  vOut = vA * vS;
          default: vOut = '0;
        endcase
        if (w_legal && (r < int'(r_n)) && (c < int'(r_n))) begin
          w_execRes[(r*DIM+c)*ELEM_W +: ELEM_W] = satVal(vOut);
          w_execOvf = w_execOvf | isSat(vOut);
        end
      end
    end
  end

  // Dot product for the current (row, col); terms beyond n are masked out.
  always_comb begin
    logic signed [ACC_W-1:0] vProd;
    w_dot = '0;
    for (int i = 0; i < DIM; i++) begin
      vProd = ext(r_a[(int'(r_row)*DIM+i)*ELEM_W +: ELEM_W])
            * ext(r_b[(i*DIM+int'(r_col))*ELEM_W +: ELEM_W]);
      if (i < int'(r_n)) w_dot = w_dot + vProd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_scalar   <= '0;
      r_op       <= '0;
      r_n        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= matrizA;
            r_b        <= matrizB;
            r_scalar   <= scalar;
            r_op       <= opcode;
            r_n        <= size;
            r_row      <= '0;
            r_col      <= '0;
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
            r_busy     <= 1'b1;
            // An illegal size on a multiply takes the EXEC path and reports invalid there.
            if (opcode == OP_MUL && size != 3'd0 && size <= DIM_N) begin
              r_result <= '0;
              r_state  <= S_MUL;
            end else begin
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_result   <= w_execRes;
          r_overflow <= w_execOvf;
          r_invalid  <= !w_legal;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_DONE;
        end
        S_MUL: begin
          r_result[(int'(r_row)*DIM+int'(r_col))*ELEM_W +: ELEM_W] <= satVal(w_dot);
          r_overflow <= r_overflow | isSat(w_dot);
          if (r_col == r_n - 3'd1) begin
            r_col <= '0;
            if (r_row == r_n - 3'd1) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_row <= r_row + 3'd1;
            end
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        S_DONE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result     = r_result;
  assign done       = r_done;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign invalid_op = r_invalid;

endmodule
